// File: rtl/fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// fa_bist_ctrl
//
// Built-in self-test driver for 1-bit full adders. It sweeps the eight input
// vectors {ci,a,b} = 000..111 into up to three adder instances that share the
// same stimulus. Each vector is held for SETTLE cycles. In the following
// CHECK cycle every DUT's {s,co} is compared against the golden full-adder
// result, and the outcome is accumulated into an error count, a per-DUT fail
// mask and the first failing vector.
//
// Parameters
//   N_DUT   number of DUTs checked in parallel (1..3)
//   SETTLE  cycles a vector is held before it is sampled (>=1)
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   start           begin a sweep; only looked at while idle
//   dut_ci/a/b      shared stimulus to all DUTs
//   dut_s, dut_co   sum / carry-out from each DUT, bit i = DUT i
//   busy            high from the cycle after start until done
//   done            one-cycle pulse at the end of a sweep
//   pass            err_cnt==0, valid from done until the next start
//   err_cnt         number of failing (DUT,vector) pairs, 0..24
//   err_mask        bit i set if DUT i failed any vector
//   first_fail_vec  first failing {ci,a,b}, meaningful when err_cnt>0
// ---------------------------------------------------------------------------
module fa_bist_ctrl #(
    parameter int N_DUT  = 3,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_ci,
    output logic             dut_a,
    output logic             dut_b,
    input  logic [N_DUT-1:0] dut_s,
    input  logic [N_DUT-1:0] dut_co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [N_DUT-1:0] err_mask,
    output logic [2:0]       first_fail_vec
);

    localparam int               CNT_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_VEC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [2:0]       vec;
    logic [2:0]       vec_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;
    logic             done_d;
    logic             pass_d;
    logic [4:0]       err_cnt_d;
    logic [N_DUT-1:0] err_mask_d;
    logic [2:0]       first_fail_vec_d;

    logic             gs;
    logic             gco;
    logic [N_DUT-1:0] fail;

    // Golden full adder, vector packed as {ci,a,b}.
    function automatic logic golden_s(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic golden_co(input logic [2:0] v);
        return (v[1] & v[0]) | (v[2] & (v[1] ^ v[0]));
    endfunction

    // Number of set bits in a per-DUT fail vector (at most 3).
    function automatic logic [4:0] popcount(input logic [N_DUT-1:0] m);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < N_DUT; i++) begin
            n = n + 5'(m[i]);
        end
        return n;
    endfunction

    // The vector register is the stimulus itself, so the DUT inputs are
    // glitch-free flop outputs and stay at the last vector while idle.
    assign {dut_ci, dut_a, dut_b} = vec;

    assign gs   = golden_s(vec);
    assign gco  = golden_co(vec);
    // A DUT counts once per vector even when both of its outputs are wrong.
    assign fail = (dut_s ^ {N_DUT{gs}}) | (dut_co ^ {N_DUT{gco}});

    always_comb begin
        state_d          = state;
        vec_d            = vec;
        cnt_d            = cnt;
        busy_d           = busy;
        done_d           = 1'b0;
        pass_d           = pass;
        err_cnt_d        = err_cnt;
        err_mask_d       = err_mask;
        first_fail_vec_d = first_fail_vec;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    vec_d            = 3'd0;
                    cnt_d            = CNT_LOAD;
                    busy_d           = 1'b1;
                    pass_d           = 1'b0;
                    err_cnt_d        = 5'd0;
                    err_mask_d       = '0;
                    first_fail_vec_d = 3'd0;
                    state_d          = ST_WAIT;
                end
            end

            // cnt starts at SETTLE and leaves on 1, giving exactly SETTLE
            // WAIT cycles per vector.
            ST_WAIT: begin
                cnt_d = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                err_cnt_d  = err_cnt + popcount(fail);
                err_mask_d = err_mask | fail;
                // err_cnt is still zero only until the first failing vector.
                if ((fail != '0) && (err_cnt == 5'd0)) begin
                    first_fail_vec_d = vec;
                end
                if (vec != LAST_VEC) begin
                    vec_d   = vec + 3'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end

            // err_cnt already holds the final CHECK update here.
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt == 5'd0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec            <= 3'd0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 5'd0;
            err_mask       <= '0;
            first_fail_vec <= 3'd0;
        end else begin
            state          <= state_d;
            vec            <= vec_d;
            cnt            <= cnt_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_cnt        <= err_cnt_d;
            err_mask       <= err_mask_d;
            first_fail_vec <= first_fail_vec_d;
        end
    end

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fa_bist_ctrl
//
// Two controllers:
//   u_main  N_DUT=3, SETTLE=2. Its lanes are combinational full adders with
//           per-vector fault tables, or, with lat_mode set, fault-free adders
//           whose outputs lag the stimulus by two cycles.
//   u_slow  N_DUT=1, SETTLE=1. Its lane is a fault-free adder lagging two
//           cycles.
//
// The reference model builds the stimulus timeline (prior value, then each
// vector held SETTLE+1 cycles). It works out what every lane shows at each
// sampling point, then derives the expected sweep results arithmetically.
// ---------------------------------------------------------------------------
module tb_fa_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start0;
    logic       start1;
    logic       ci0, a0, b0;
    logic       ci1, a1, b1;
    logic [2:0] s0, co0;
    logic [0:0] s1, co1;
    logic       busy0, done0, pass0;
    logic       busy1, done1, pass1;
    logic [4:0] cnt0, cnt1;
    logic [2:0] mask0;
    logic [0:0] mask1;
    logic [2:0] ffv0, ffv1;

    logic [2:0] stim0, stim1;
    logic [2:0] d1_0, d2_0, d1_1, d2_1;
    logic [1:0] r_now0, r_del0, r_del1;
    logic [7:0] fs [3];
    logic [7:0] fc [3];
    logic       lat_mode;

    int n_vec;
    int n_err;
    int prior0, prior1;
    int e_cnt, e_mask, e_ffv;

    fa_bist_ctrl #(.N_DUT(3), .SETTLE(2)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .dut_ci(ci0), .dut_a(a0), .dut_b(b0),
        .dut_s(s0), .dut_co(co0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(cnt0), .err_mask(mask0), .first_fail_vec(ffv0)
    );

    fa_bist_ctrl #(.N_DUT(1), .SETTLE(1)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .dut_ci(ci1), .dut_a(a1), .dut_b(b1),
        .dut_s(s1), .dut_co(co1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(cnt1), .err_mask(mask1), .first_fail_vec(ffv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference full adder by counting ones: returns {s,co}.
    function automatic logic [1:0] fa_ref(input logic [2:0] v);
        int sum;
        sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return {1'(sum % 2), 1'(sum / 2)};
    endfunction

    assign stim0  = {ci0, a0, b0};
    assign stim1  = {ci1, a1, b1};
    assign r_now0 = fa_ref(stim0);
    assign r_del0 = fa_ref(d2_0);
    assign r_del1 = fa_ref(d2_1);

    always_ff @(posedge clk) begin
        d1_0 <= stim0;
        d2_0 <= d1_0;
        d1_1 <= stim1;
        d2_1 <= d1_1;
    end

    always_comb begin
        s0 = '0;
        co0 = '0;
        for (int i = 0; i < 3; i++) begin
            if (lat_mode) begin
                s0[i]  = r_del0[1];
                co0[i] = r_del0[0];
            end else begin
                s0[i]  = r_now0[1] ^ fs[i][stim0];
                co0[i] = r_now0[0] ^ fc[i][stim0];
            end
        end
    end

    assign s1[0]  = r_del1[1];
    assign co1[0] = r_del1[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic d, output logic [2:0] st,
                          output logic [4:0] c, output logic [2:0] m, output logic [2:0] f,
                          output logic p);
        if (sel == 0) begin
            b = busy0; d = done0; st = stim0; c = cnt0; m = mask0; f = ffv0; p = pass0;
        end else begin
            b = busy1; d = done1; st = stim1; c = cnt1; m = {2'b00, mask1}; f = ffv1; p = pass1;
        end
    endtask

    // Expected results of one full sweep on instance sel.
    task automatic model(input int sel, output int ecnt, output int emask, output int effv);
        int         tl[$];
        int         s_cyc, n_lane, lat, prior, pos;
        bit         seen, vfail;
        logic [2:0] src;
        logic [1:0] want, got;
        s_cyc  = (sel == 0) ? 2 : 1;
        n_lane = (sel == 0) ? 3 : 1;
        lat    = (sel == 1 || lat_mode) ? 2 : 0;
        prior  = (sel == 0) ? prior0 : prior1;
        for (int k = 0; k < 4; k++) tl.push_back(prior);
        for (int v = 0; v < 8; v++)
            for (int k = 0; k <= s_cyc; k++) tl.push_back(v);
        ecnt = 0; emask = 0; effv = 0; seen = 0;
        for (int v = 0; v < 8; v++) begin
            pos   = 4 + v * (s_cyc + 1) + s_cyc;
            src   = 3'(tl[pos - lat]);
            want  = fa_ref(3'(v));
            vfail = 0;
            for (int i = 0; i < n_lane; i++) begin
                got = fa_ref(src);
                if (sel == 0 && !lat_mode) got = got ^ {fs[i][src], fc[i][src]};
                if (got != want) begin
                    ecnt++;
                    emask = emask | (1 << i);
                    vfail = 1;
                end
            end
            if (vfail && !seen) begin
                effv = v;
                seen = 1;
            end
        end
    endtask

    // Call just after a negedge with the instance idle; returns at the
    // negedge of the done cycle.
    task automatic run_sweep(input int sel, input bit hold);
        int s_cyc, dl, estim;
        logic b, d, p;
        logic [2:0] st, m, f;
        logic [4:0] c;
        s_cyc = (sel == 0) ? 2 : 1;
        dl    = 8 * (s_cyc + 1) + 1;
        model(sel, e_cnt, e_mask, e_ffv);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
        for (int e = 0; e <= dl; e++) begin
            @(negedge clk);
            sample(sel, b, d, st, c, m, f, p);
            if (e == 0) begin
                chk($sformatf("s%0d_clr_cnt", sel), c, 0);
                chk($sformatf("s%0d_clr_mask", sel), m, 0);
                chk($sformatf("s%0d_clr_pass", sel), p, 0);
            end
            if (e < dl) begin
                estim = (e < 8 * (s_cyc + 1)) ? e / (s_cyc + 1) : 7;
                chk($sformatf("s%0d_stim_c%0d", sel, e), st, estim);
                chk($sformatf("s%0d_busy_done_c%0d", sel, e), {b, d}, 2'b10);
            end else begin
                chk($sformatf("s%0d_done_c%0d", sel, e), {b, d}, 2'b01);
                chk($sformatf("s%0d_err_cnt", sel), c, e_cnt);
                chk($sformatf("s%0d_err_mask", sel), m, e_mask);
                chk($sformatf("s%0d_first_fail", sel), f, e_ffv);
                chk($sformatf("s%0d_pass", sel), p, (e_cnt == 0));
            end
        end
        if (sel == 0) prior0 = 7; else prior1 = 7;
    endtask

    task automatic check_idle(input int sel);
        logic b, d, p;
        logic [2:0] st, m, f;
        logic [4:0] c;
        repeat (3) @(negedge clk);
        sample(sel, b, d, st, c, m, f, p);
        chk($sformatf("s%0d_idle_busy_done", sel), {b, d}, 2'b00);
        chk($sformatf("s%0d_idle_stim", sel), st, 7);
        chk($sformatf("s%0d_idle_cnt", sel), c, e_cnt);
        chk($sformatf("s%0d_idle_mask", sel), m, e_mask);
        chk($sformatf("s%0d_idle_pass", sel), p, (e_cnt == 0));
    endtask

    task automatic check_zero(input int sel, input string pfx);
        logic b, d, p;
        logic [2:0] st, m, f;
        logic [4:0] c;
        sample(sel, b, d, st, c, m, f, p);
        chk({pfx, "_busy"}, b, 0);
        chk({pfx, "_done"}, d, 0);
        chk({pfx, "_stim"}, st, 0);
        chk({pfx, "_cnt"}, c, 0);
        chk({pfx, "_mask"}, m, 0);
        chk({pfx, "_ffv"}, f, 0);
        chk({pfx, "_pass"}, p, 0);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 3; i++) begin
            fs[i] = 8'h00;
            fc[i] = 8'h00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; lat_mode = 1'b0;
        prior0 = 0; prior1 = 0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0, "rst_main");
        check_zero(1, "rst_slow");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // all three adders correct
        run_sweep(0, 0);
        chk("t1_pass", pass0, 1);
        chk("t1_cnt", cnt0, 0);
        chk("t1_mask", mask0, 0);
        check_idle(0);

        // DUT1 carry stuck at 0
        clear_faults();
        fc[1] = 8'hE8;
        run_sweep(0, 0);
        chk("t2_cnt", cnt0, 4);
        chk("t2_mask", mask0, 3'b010);
        chk("t2_ffv", ffv0, 3);
        chk("t2_pass", pass0, 0);
        check_idle(0);

        // DUT0 sum inverted, DUT2 sum and carry inverted
        clear_faults();
        fs[0] = 8'hFF; fs[2] = 8'hFF; fc[2] = 8'hFF;
        run_sweep(0, 0);
        chk("t3_cnt", cnt0, 16);
        chk("t3_mask", mask0, 3'b101);
        chk("t3_ffv", ffv0, 0);
        check_idle(0);

        // random sparse fault tables
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 3; i++) begin
                fs[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
                fc[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
            end
            run_sweep(0, 0);
            check_idle(0);
        end

        // start held high: the second sweep launches right after done
        clear_faults();
        fs[0] = 8'h10;
        run_sweep(0, 1);
        run_sweep(0, 1);
        start0 = 1'b0;
        check_idle(0);

        // reset while vector 100 is in WAIT
        clear_faults();
        fs[1] = 8'h03;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t4_pre_stim", stim0, 4);
        chk("t4_pre_cnt", cnt0, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero(0, "t4_after_rst");
        saw_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) saw_done = 1;
        end
        chk("t4_no_done", saw_done, 0);
        prior0 = 0; prior1 = 0;
        run_sweep(0, 0);
        check_idle(0);

        // outputs lagging two cycles: enough settle at 2, too little at 1
        clear_faults();
        lat_mode = 1'b1;
        repeat (3) @(negedge clk);
        run_sweep(0, 0);
        chk("t6_lag_settle2_pass", pass0, 1);
        run_sweep(1, 0);
        chk("t6_lag_settle1_errs", (cnt1 > 5'd0), 1);
        check_idle(1);
        run_sweep(1, 0);
        check_idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
